keypad_debouncer_rpt: RTL and testbench

Parametrised second-generation keypad debouncer that sits between the keypad column scanner and the display/command logic. It debounces both press and release, latches the key code, and freezes the scanner while a key is owned. It optionally generates typematic auto-repeat pulses while a key is held. Key width and all timing are parameters, so the same block serves 4x4 and larger matrices at any clock rate.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_timer.sv | 49 ++++
 rtl/keypad_debouncer_rpt.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_debouncer_rpt.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and defaults for the keypad debouncer slice.
//   - debounce_state_t : ownership state of the debouncer FSM
//   - DEF_*            : default widths and timing for a 3 MHz system clock
//   - max4()           : constant helper used to size the shared counter
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } debounce_state_t;

    localparam int DEF_KEY_W           = 4;
    localparam int DEF_COL_W           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 60000;    // 20 ms @ 3 MHz
    localparam int DEF_RELEASE_CYCLES  = 60000;    // 20 ms @ 3 MHz
    localparam int DEF_REPEAT_DELAY    = 1500000;  // 500 ms @ 3 MHz
    localparam int DEF_REPEAT_PERIOD   = 300000;   // 100 ms @ 3 MHz

    // Largest of four values, evaluated at elaboration to size the counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// ---------------------------------------------------------------------------
// keypad_timer
// Loadable, clearable, saturating up-counter with an equality compare.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear to zero (highest priority)
//   load        : synchronous load of load_value
//   load_value  : value taken when load=1
//   inc         : count up by one, sticking at all-ones
//   cmp_value   : compare target
//   expired     : high while the count equals cmp_value
// ---------------------------------------------------------------------------
module keypad_timer
    import keypad_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             inc,
    input  logic [CNT_W-1:0] cmp_value,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    // Counter register: clear wins over load, load wins over increment, and
    // the increment stops at all-ones so the count can never wrap back to a
    // small value and fake an expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == cmp_value);

endmodule

// File: rtl/keypad_debouncer_rpt.sv
// ---------------------------------------------------------------------------
// keypad_debouncer_rpt
// Press/release debouncer with key latching, scanner freeze and optional
// typematic auto-repeat.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_detected   : scanner sees a key on the current column
//   key_code       : scanner key code (only meaningful with key_detected)
//   col            : active column pattern, captured together with the key
//   repeat_en      : enables auto-repeat while a key is held
//   key_valid      : one-cycle pulse for an accepted press or a repeat
//   is_repeat      : qualifies key_valid, 1 = repeat pulse
//   debounced_key  : latched key code of the last accepted press
//   held_col       : latched column of the last accepted press
//   key_held       : a key is owned (HELD or RELEASE_DB)
//   key_released   : one-cycle pulse when an owned key is freed
//   scan_stop      : scanner must hold its current column
// ---------------------------------------------------------------------------
module keypad_debouncer_rpt
    import keypad_pkg::*;
#(
    parameter int KEY_W           = DEF_KEY_W,
    parameter int COL_W           = DEF_COL_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RELEASE_CYCLES  = DEF_RELEASE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = $clog2(max4(DEBOUNCE_CYCLES, RELEASE_CYCLES,
                                                REPEAT_DELAY, REPEAT_PERIOD)) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_detected,
    input  logic [KEY_W-1:0] key_code,
    input  logic [COL_W-1:0] col,
    input  logic             repeat_en,
    output logic             key_valid,
    output logic             is_repeat,
    output logic [KEY_W-1:0] debounced_key,
    output logic [COL_W-1:0] held_col,
    output logic             key_held,
    output logic             key_released,
    output logic             scan_stop
);

    // A timing value below 2 would let two pulses land on adjacent cycles.
    if ((DEBOUNCE_CYCLES < 2) || (RELEASE_CYCLES < 2) ||
        (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_bad_timing
        $error("keypad_debouncer_rpt: every timing parameter must be >= 2");
    end

    // Expiry points: the phase ends on the edge where the count already
    // reads N-1, so each phase lasts N edges after the edge that cleared it.
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    debounce_state_t  state;
    debounce_state_t  state_nxt;
    logic             rpt_phase;
    logic             rpt_phase_nxt;
    logic [KEY_W-1:0] cand_key;
    logic [COL_W-1:0] cand_col;

    logic             tmr_clear;
    logic             tmr_inc;
    logic             tmr_expired;
    logic [CNT_W-1:0] tmr_cmp;

    logic             capture;
    logic             accept;
    logic             repeat_fire;
    logic             release_fire;

    logic             cand_match;
    logic             owned_match;

    assign cand_match  = (key_code == cand_key);
    assign owned_match = (key_code == debounced_key);

    // One counter serves every phase; only the compare target changes with
    // the state. In HELD, rpt_phase picks the long first delay (0) or the
    // shorter period between subsequent repeats (1).
    always_comb begin
        tmr_cmp = DB_LAST;
        case (state)
            PRESS_DB:   tmr_cmp = DB_LAST;
            HELD:       tmr_cmp = rpt_phase ? RP_LAST : RD_LAST;
            RELEASE_DB: tmr_cmp = REL_LAST;
            default:    tmr_cmp = DB_LAST;
        endcase
    end

    keypad_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (tmr_clear),
        .load       (1'b0),
        .load_value ('0),
        .inc        (tmr_inc),
        .cmp_value  (tmr_cmp),
        .expired    (tmr_expired)
    );

    // State and repeat-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rpt_phase <= 1'b0;
        end else begin
            state     <= state_nxt;
            rpt_phase <= rpt_phase_nxt;
        end
    end

    // Next-state and per-cycle control. The timer is cleared on every state
    // change so each phase measures from the edge that entered it. In HELD,
    // a different code with key_detected=1 still counts as the key being
    // down: it neither releases the key nor disturbs the repeat timing.
    always_comb begin
        state_nxt     = state;
        rpt_phase_nxt = rpt_phase;
        tmr_clear     = 1'b0;
        tmr_inc       = 1'b0;
        capture       = 1'b0;
        accept        = 1'b0;
        repeat_fire   = 1'b0;
        release_fire  = 1'b0;

        case (state)
            IDLE: begin
                if (key_detected) begin
                    capture   = 1'b1;
                    tmr_clear = 1'b1;
                    state_nxt = PRESS_DB;
                end
            end

            PRESS_DB: begin
                if (!key_detected) begin
                    tmr_clear = 1'b1;
                    state_nxt = IDLE;
                end else if (!cand_match) begin
                    capture   = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    accept        = 1'b1;
                    tmr_clear     = 1'b1;
                    rpt_phase_nxt = 1'b0;
                    state_nxt     = HELD;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            HELD: begin
                if (!key_detected) begin
                    tmr_clear = 1'b1;
                    state_nxt = RELEASE_DB;
                end else if (!repeat_en) begin
                    tmr_clear     = 1'b1;
                    rpt_phase_nxt = 1'b0;
                end else if (tmr_expired) begin
                    repeat_fire   = 1'b1;
                    tmr_clear     = 1'b1;
                    rpt_phase_nxt = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            RELEASE_DB: begin
                if (!key_detected) begin
                    if (tmr_expired) begin
                        release_fire = 1'b1;
                        tmr_clear    = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end else if (owned_match) begin
                    tmr_clear     = 1'b1;
                    rpt_phase_nxt = 1'b0;
                    state_nxt     = HELD;
                end else begin
                    release_fire = 1'b1;
                    capture      = 1'b1;
                    tmr_clear    = 1'b1;
                    state_nxt    = PRESS_DB;
                end
            end

            default: begin
                tmr_clear = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Candidate registers hold the code/column being debounced until it is
    // either accepted or replaced by a different code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_key <= '0;
            cand_col <= '0;
        end else if (capture) begin
            cand_key <= key_code;
            cand_col <= col;
        end
    end

    // Registered pulse outputs and the latched key/column. The latched
    // values survive release and change only on the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid     <= 1'b0;
            is_repeat     <= 1'b0;
            key_released  <= 1'b0;
            debounced_key <= '0;
            held_col      <= '0;
        end else begin
            key_valid    <= accept | repeat_fire;
            is_repeat    <= repeat_fire;
            key_released <= release_fire;
            if (accept) begin
                debounced_key <= cand_key;
                held_col      <= cand_col;
            end
        end
    end

    assign key_held  = (state == HELD) || (state == RELEASE_DB);
    assign scan_stop = (state != IDLE);

endmodule

// File: tb/tb_keypad_debouncer_rpt.sv
// ---------------------------------------------------------------------------
// tb_keypad_debouncer_rpt
// Self-checking bench for keypad_debouncer_rpt with short timing parameters.
// Directed scenarios followed by randomized press/release/bounce segments,
// every cycle compared against a sample-counting reference model.
// ---------------------------------------------------------------------------
module tb_keypad_debouncer_rpt;

    localparam int KEY_W = 4;
    localparam int COL_W = 4;
    localparam int DB    = 8;
    localparam int REL   = 4;
    localparam int RD    = 20;
    localparam int RP    = 5;

    logic             clk;
    logic             rst_n;
    logic             key_detected;
    logic [KEY_W-1:0] key_code;
    logic [COL_W-1:0] col;
    logic             repeat_en;
    logic             key_valid;
    logic             is_repeat;
    logic [KEY_W-1:0] debounced_key;
    logic [COL_W-1:0] held_col;
    logic             key_held;
    logic             key_released;
    logic             scan_stop;

    int errors;
    int checks;
    int cycle;

    keypad_debouncer_rpt #(
        .KEY_W           (KEY_W),
        .COL_W           (COL_W),
        .DEBOUNCE_CYCLES (DB),
        .RELEASE_CYCLES  (REL),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_detected  (key_detected),
        .key_code      (key_code),
        .col           (col),
        .repeat_en     (repeat_en),
        .key_valid     (key_valid),
        .is_repeat     (is_repeat),
        .debounced_key (debounced_key),
        .held_col      (held_col),
        .key_held      (key_held),
        .key_released  (key_released),
        .scan_stop     (scan_stop)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, phrased as runs of samples:
    //   - a press is accepted on the (DB+1)th consecutive sample of one code
    //     (the capturing sample counts as the first);
    //   - an owned key is freed on the (REL+1)th consecutive low sample;
    //   - while held with repeat enabled, a repeat fires on the RD-th enabled
    //     sample after acceptance / re-enable / bounce-return, then every RP.
    localparam int M_FREE = 0, M_PRESSING = 1, M_OWNED = 2, M_RELEASING = 3;

    int               m_mode;
    int               m_run;
    int               m_low;
    int               m_hold;
    int               m_gap;
    logic [KEY_W-1:0] m_cand;
    logic [COL_W-1:0] m_cand_col;
    logic [KEY_W-1:0] m_key;
    logic [COL_W-1:0] m_col;
    logic             e_valid;
    logic             e_repeat;
    logic             e_released;

    task automatic modelReset();
        m_mode     = M_FREE;
        m_run      = 0;
        m_low      = 0;
        m_hold     = 0;
        m_gap      = RD;
        m_cand     = '0;
        m_cand_col = '0;
        m_key      = '0;
        m_col      = '0;
        e_valid    = 1'b0;
        e_repeat   = 1'b0;
        e_released = 1'b0;
    endtask

    task automatic modelStep(input logic kd, input logic [KEY_W-1:0] code,
                             input logic [COL_W-1:0] c, input logic ren);
        e_valid    = 1'b0;
        e_repeat   = 1'b0;
        e_released = 1'b0;
        case (m_mode)
            M_FREE: begin
                if (kd) begin
                    m_mode = M_PRESSING; m_cand = code; m_cand_col = c; m_run = 1;
                end
            end
            M_PRESSING: begin
                if (!kd) begin
                    m_mode = M_FREE;
                end else if (code != m_cand) begin
                    m_cand = code; m_cand_col = c; m_run = 1;
                end else begin
                    m_run++;
                    if (m_run == DB + 1) begin
                        m_key = m_cand; m_col = m_cand_col; e_valid = 1'b1;
                        m_mode = M_OWNED; m_hold = 0; m_gap = RD;
                    end
                end
            end
            M_OWNED: begin
                if (!kd) begin
                    m_mode = M_RELEASING; m_low = 1;
                end else if (!ren) begin
                    m_hold = 0; m_gap = RD;
                end else begin
                    m_hold++;
                    if (m_hold == m_gap) begin
                        e_valid = 1'b1; e_repeat = 1'b1; m_hold = 0; m_gap = RP;
                    end
                end
            end
            default: begin
                if (!kd) begin
                    m_low++;
                    if (m_low == REL + 1) begin
                        e_released = 1'b1; m_mode = M_FREE;
                    end
                end else if (code == m_key) begin
                    m_mode = M_OWNED; m_hold = 0; m_gap = RD;
                end else begin
                    e_released = 1'b1;
                    m_mode = M_PRESSING; m_cand = code; m_cand_col = c; m_run = 1;
                end
            end
        endcase
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)",
                     tag, observed, expected, cycle);
        end
    endtask

    task automatic checkAll();
        checkOutput("key_valid",     32'(key_valid),     32'(e_valid));
        checkOutput("is_repeat",     32'(is_repeat),     32'(e_repeat));
        checkOutput("key_released",  32'(key_released),  32'(e_released));
        checkOutput("debounced_key", 32'(debounced_key), 32'(m_key));
        checkOutput("held_col",      32'(held_col),      32'(m_col));
        checkOutput("key_held",      32'(key_held),
                    32'((m_mode == M_OWNED) || (m_mode == M_RELEASING)));
        checkOutput("scan_stop",     32'(scan_stop),     32'(m_mode != M_FREE));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"},    32'(key_valid),     32'd0);
        checkOutput({tag, "_repeat"},   32'(is_repeat),     32'd0);
        checkOutput({tag, "_released"}, 32'(key_released),  32'd0);
        checkOutput({tag, "_key"},      32'(debounced_key), 32'd0);
        checkOutput({tag, "_col"},      32'(held_col),      32'd0);
        checkOutput({tag, "_held"},     32'(key_held),      32'd0);
        checkOutput({tag, "_scan"},     32'(scan_stop),     32'd0);
    endtask

    // Drive one cycle of inputs, let the edge sample them, step the model
    // with the same values and compare shortly after the edge.
    task automatic applyStimulus(input logic kd, input logic [KEY_W-1:0] code,
                                 input logic [COL_W-1:0] c, input logic ren);
        key_detected = kd;
        key_code     = code;
        col          = c;
        repeat_en    = ren;
        @(posedge clk);
        modelStep(kd, code, c, ren);
        #1;
        cycle++;
        checkAll();
    endtask

    task automatic hold(input logic kd, input logic [KEY_W-1:0] code,
                        input logic [COL_W-1:0] c, input logic ren, input int n);
        for (int i = 0; i < n; i++) applyStimulus(kd, code, c, ren);
    endtask

    // Asynchronous reset between edges: outputs must clear before any edge.
    task automatic applyReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero(tag);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkAllZero({tag, "_rel"});
    endtask

    initial begin
        logic [KEY_W-1:0] r_code;
        logic [COL_W-1:0] r_col;
        logic             r_ren;
        int               r_len;
        int               r_kind;

        errors       = 0;
        checks       = 0;
        cycle        = 0;
        rst_n        = 1'b0;
        key_detected = 1'b0;
        key_code     = '0;
        col          = '0;
        repeat_en    = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press of 0x5 / col 1101 without repeat, then release.
        hold(1'b1, 4'h5, 4'b1101, 1'b0, 30);
        checkOutput("tp1_key", 32'(debounced_key), 32'h5);
        checkOutput("tp1_col", 32'(held_col), 32'hD);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 8);
        checkOutput("tp1_scan", 32'(scan_stop), 32'd0);

        // Short press of 0xC never gets accepted.
        hold(1'b1, 4'hC, 4'b1110, 1'b0, 5);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 6);
        checkOutput("tp2_key", 32'(debounced_key), 32'h5);

        // Code changes 0x3 -> 0x7 mid-debounce; only 0x7 is accepted.
        hold(1'b1, 4'h3, 4'b1011, 1'b0, 4);
        hold(1'b1, 4'h7, 4'b0111, 1'b0, 15);
        checkOutput("tp3_key", 32'(debounced_key), 32'h7);
        checkOutput("tp3_col", 32'(held_col), 32'h7);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 8);

        // Auto-repeat on 0x9, then repeat disabled while still held.
        hold(1'b1, 4'h9, 4'b1101, 1'b1, DB + 1 + 60);
        hold(1'b1, 4'h9, 4'b1101, 1'b0, 25);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 8);

        // Foreign code while 0x7 is owned, then a short release bounce.
        hold(1'b1, 4'h7, 4'b1110, 1'b0, 12);
        hold(1'b1, 4'hA, 4'b1011, 1'b0, 5);
        checkOutput("tp5_key", 32'(debounced_key), 32'h7);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 2);
        hold(1'b1, 4'h7, 4'b1110, 1'b0, 5);
        checkOutput("tp5_held", 32'(key_held), 32'd1);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 8);

        // Reset in the middle of a press and again while held.
        hold(1'b1, 4'h6, 4'b0111, 1'b0, 4);
        applyReset("rst_press");
        hold(1'b1, 4'h6, 4'b0111, 1'b0, 14);
        applyReset("rst_held");
        hold(1'b1, 4'h6, 4'b0111, 1'b0, 5);
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 3);

        // Randomized segments: long presses, short bounces, code changes,
        // repeat toggling and the occasional reset.
        r_code = 4'h1;
        r_col  = 4'b1110;
        for (int seg = 0; seg < 90; seg++) begin
            r_kind = int'($urandom_range(0, 9));
            r_ren  = 1'($urandom_range(0, 1));
            if (r_kind <= 3) begin
                if ($urandom_range(0, 2) != 0) begin
                    r_code = 4'($urandom_range(0, 15));
                    r_col  = 4'($urandom_range(0, 15));
                end
                r_len = int'($urandom_range(1, 45));
                hold(1'b1, r_code, r_col, r_ren, r_len);
            end else if (r_kind <= 6) begin
                r_len = int'($urandom_range(1, 8));
                hold(1'b0, 4'($urandom_range(0, 15)), 4'b0000, r_ren, r_len);
            end else if (r_kind <= 8) begin
                r_len = int'($urandom_range(1, 12));
                for (int i = 0; i < r_len; i++) begin
                    applyStimulus(1'b1,
                                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : r_code,
                                  r_col, 1'($urandom_range(0, 1)));
                end
            end else begin
                applyReset("rst_rand");
            end
        end
        hold(1'b0, 4'h0, 4'b0000, 1'b0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
